approx_iterative_divider: RTL and testbench

- Parametrised, multi-cycle restoring radix-2 divider for the approximate arithmetic unit set; computes one quotient bit per cycle.
- Run-time accuracy control: `accuracy` sets how many quotient LSBs are skipped, so lower accuracy means fewer cycles.
- Sits beside the execute stage: start/busy/done handshake, results held until the next start.

---
 rtl/approx_arith_pkg.sv | 14 +
 rtl/approx_div_step.sv | 19 +
 rtl/approx_iterative_divider.sv | 139 +++++++++++++
 tb/tb_approx_iterative_divider.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/approx_arith_pkg.sv
// Shared types, constants and helpers for the approximate arithmetic unit set.
package approx_arith_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIN} div_state_t;

    // Wide enough for any supported operand width; each unit slices what it needs.
    localparam logic [63:0] DIV_BY_ZERO_Q = '1;

    function automatic int unsigned clamp_accuracy(input int unsigned acc,
                                                   input int unsigned width);
        return (acc > width - 1) ? width - 1 : acc;
    endfunction

endpackage

// File: rtl/approx_div_step.sv
// One restoring radix-2 division step: shift in the next dividend bit, try to subtract the divisor.
module approx_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             quot_bit
);

    // The partial remainder is always below the divisor, so only the shifted value needs WIDTH+1 bits.
    logic [WIDTH:0] shifted;

    assign shifted  = {rem_in, next_bit};
    assign quot_bit = (shifted >= {1'b0, divisor});
    assign rem_out  = quot_bit ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];

endmodule

// File: rtl/approx_iterative_divider.sv
// Multi-cycle restoring divider with run-time accuracy (skipped quotient LSBs).
// Optional signed operation is enabled with the APPROX_DIVIDER_SIGNED_EN macro.
module approx_iterative_divider
    import approx_arith_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     input_1,
    input  logic [WIDTH-1:0]     input_2,
    input  logic [ACC_WIDTH-1:0] accuracy,
`ifdef APPROX_DIVIDER_SIGNED_EN
    input  logic                 signed_op,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [WIDTH-1:0]     remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t state, next_state;

    logic [WIDTH-1:0] dividend_q, divisor_q, shift_q, rem_q;
    logic [WIDTH-2:0] quot_q;
    logic [CW-1:0]    k_q, count_q, k_in;
    logic             neg_quot_q, neg_rem_q;

    logic [WIDTH-1:0] mag_1, mag_2, step_rem, quot_next, quot_mag, rem_mag, low_mask;
    logic             step_bit, div_zero, overflow, in_neg_quot, in_neg_rem;

    assign div_zero = (input_2 == '0);
    assign k_in     = CW'(clamp_accuracy(32'(accuracy), WIDTH));

`ifdef APPROX_DIVIDER_SIGNED_EN
    logic neg_1, neg_2;
    assign neg_1       = signed_op & input_1[WIDTH-1];
    assign neg_2       = signed_op & input_2[WIDTH-1];
    assign mag_1       = neg_1 ? -input_1 : input_1;
    assign mag_2       = neg_2 ? -input_2 : input_2;
    assign in_neg_quot = neg_1 ^ neg_2;
    assign in_neg_rem  = neg_1;
    assign overflow    = signed_op && (input_1 == {1'b1, {(WIDTH-1){1'b0}}}) && (input_2 == '1);
`else
    assign mag_1       = input_1;
    assign mag_2       = input_2;
    assign in_neg_quot = 1'b0;
    assign in_neg_rem  = 1'b0;
    assign overflow    = 1'b0;
`endif

    approx_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in   (rem_q),
        .next_bit (shift_q[WIDTH-1]),
        .divisor  (divisor_q),
        .rem_out  (step_rem),
        .quot_bit (step_bit)
    );

    // Skipped quotient LSBs stay zero; the skipped dividend bits fold back into the remainder.
    assign quot_next = {quot_q, step_bit};
    assign low_mask  = ~({WIDTH{1'b1}} << k_q);
    assign quot_mag  = quot_next << k_q;
    assign rem_mag   = (step_rem << k_q) | (dividend_q & low_mask);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = (div_zero || overflow) ? FIN : CALC;
            CALC: if (count_q == CW'(1)) next_state = FIN;
            FIN:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == FIN);
    end

    // Operand capture, iteration and result write-back; results only change on entry to FIN.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            dividend_q <= '0;
            divisor_q  <= '0;
            shift_q    <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            k_q        <= '0;
            count_q    <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result     <= '0;
            remainder  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    dividend_q <= mag_1;
                    divisor_q  <= mag_2;
                    shift_q    <= mag_1;
                    rem_q      <= '0;
                    quot_q     <= '0;
                    k_q        <= k_in;
                    count_q    <= CW'(WIDTH) - k_in;
                    neg_quot_q <= in_neg_quot;
                    neg_rem_q  <= in_neg_rem;
                    if (div_zero) begin
                        result    <= DIV_BY_ZERO_Q[WIDTH-1:0];
                        remainder <= input_1;
                    end else if (overflow) begin
                        result    <= input_1;
                        remainder <= '0;
                    end
                end
                CALC: begin
                    shift_q <= shift_q << 1;
                    rem_q   <= step_rem;
                    quot_q  <= quot_next[WIDTH-2:0];
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        result    <= neg_quot_q ? -quot_mag : quot_mag;
                        remainder <= neg_rem_q ? -rem_mag : rem_mag;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_iterative_divider.sv
// Self-checking bench for approx_iterative_divider: arithmetic reference model plus directed vectors.
module tb_approx_iterative_divider;

    localparam int WIDTH     = 32;
    localparam int ACC_WIDTH = 8;

    logic                 CLK = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [WIDTH-1:0]     input_1 = '0;
    logic [WIDTH-1:0]     input_2 = '0;
    logic [ACC_WIDTH-1:0] accuracy = '0;
    logic                 busy, done;
    logic [WIDTH-1:0]     result, remainder;

    int tests_run = 0;
    int tests_failed = 0;

    approx_iterative_divider #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .start     (start),
        .input_1   (input_1),
        .input_2   (input_2),
        .accuracy  (accuracy),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .remainder (remainder)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: quotient/remainder from plain arithmetic, latency from the operation count.
    bit               m_busy = 0, m_done = 0;
    logic [WIDTH-1:0] m_res = '0, m_rem = '0, m_pend_res = '0, m_pend_rem = '0;
    int               m_elapsed = 0, m_lat = 0;

    always @(posedge CLK or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_res = '0; m_rem = '0; m_elapsed = 0;
        end else if (m_busy) begin
            m_elapsed++;
            if (m_elapsed == m_lat) m_busy = 0;
            m_done = m_busy && (m_elapsed == m_lat - 1);
            if (m_done) begin m_res = m_pend_res; m_rem = m_pend_rem; end
        end else if (start) begin
            int k;
            logic [63:0] a, b, mask;
            k = (int'(accuracy) > WIDTH - 1) ? WIDTH - 1 : int'(accuracy);
            a = 64'(input_1);
            b = 64'(input_2);
            if (b == 0) begin
                m_pend_res = '1;
                m_pend_rem = input_1;
                m_lat = 1;
            end else begin
                mask = (64'd1 << k) - 64'd1;
                m_pend_res = WIDTH'(((a >> k) / b) << k);
                m_pend_rem = WIDTH'((((a >> k) % b) << k) | (a & mask));
                m_lat = WIDTH - k + 1;
            end
            m_busy = 1; m_elapsed = 0;
            m_done = (m_lat == 1);
            if (m_done) begin m_res = m_pend_res; m_rem = m_pend_rem; end
        end else begin
            m_done = 0;
        end
    end

    always @(negedge CLK) begin
        checkOutput("cyc_busy", 64'(busy), 64'(m_busy));
        checkOutput("cyc_done", 64'(done), 64'(m_done));
        checkOutput("cyc_result", 64'(result), 64'(m_res));
        checkOutput("cyc_remainder", 64'(remainder), 64'(m_rem));
    end

    task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input logic [7:0] acc, input logic [31:0] exp_res,
                                 input logic [31:0] exp_rem, input int exp_lat, input int inject_at);
        int cycles = 0;
        int guard = 0;
        @(negedge CLK);
        while (busy && guard < 200) begin @(negedge CLK); guard++; end
        input_1 = a; input_2 = b; accuracy = acc; start = 1'b1;
        do begin
            @(negedge CLK);
            cycles++;
            if (cycles == 1) begin
                start = 1'b0; input_1 = $urandom; input_2 = $urandom; accuracy = 8'($urandom);
            end
            if (cycles == inject_at) begin start = 1'b1; input_1 = 9; input_2 = 3; accuracy = '0; end
            if (cycles == inject_at + 1) start = 1'b0;
        end while (!done && cycles < 100);
        checkOutput({name, "_latency"}, 64'(cycles), 64'(exp_lat));
        checkOutput({name, "_result"}, 64'(result), 64'(exp_res));
        checkOutput({name, "_remainder"}, 64'(remainder), 64'(exp_rem));
    endtask

    initial begin
        #200_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge CLK);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_result", 64'(result), 64'd0);
        checkOutput("reset_remainder", 64'(remainder), 64'd0);
        reset = 1'b0;

        applyStimulus("exact_100_7", 100, 7, 0, 14, 2, 33, -1);
        applyStimulus("trunc_100_7", 100, 7, 2, 12, 16, 31, -1);
        applyStimulus("clamp_acc200", 32'hFFFF_FFFF, 1, 200, 32'h8000_0000, 32'h7FFF_FFFF, 2, -1);
        applyStimulus("acc31_7_2", 7, 2, 31, 0, 7, 2, -1);
        applyStimulus("div_zero", 55, 0, 5, 32'hFFFF_FFFF, 55, 1, -1);
        applyStimulus("small_5_10", 5, 10, 0, 0, 5, 33, -1);
        applyStimulus("big_k8", 32'hFFFF_FFFF, 32'h0001_0000, 8, 32'h0000_FF00, 32'h00FF_FFFF, 25, -1);
        applyStimulus("big_k0", 32'hFFFF_FFFF, 32'h0001_0000, 0, 32'h0000_FFFF, 32'h0000_FFFF, 33, -1);
        applyStimulus("start_busy", 100, 7, 0, 14, 2, 33, 5);
        applyStimulus("after_busy_9_3", 9, 3, 0, 3, 0, 33, -1);

        @(negedge CLK);
        input_1 = 1000; input_2 = 3; accuracy = 0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (9) @(negedge CLK);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        checkOutput("midreset_done", 64'(done), 64'd0);
        checkOutput("midreset_result", 64'(result), 64'd0);
        checkOutput("midreset_remainder", 64'(remainder), 64'd0);
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        applyStimulus("after_reset_1000_3", 1000, 3, 0, 333, 1, 33, -1);

        repeat (3) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
